serial_paralelo_comalign_rx: RTL and testbench
==============================================

Name: serial_paralelo_comalign_rx

Overview:
- Rx-side serial-to-parallel converter with COM-character byte alignment.
- Sits directly upstream of the 1-to-2 byte demux: consumes the 1-bit line stream at clk_32f and delivers aligned bytes plus a valid flag, which the demux ingests as data_in/valid.
- Locks after COM_COUNT consecutive aligned COM characters.
- Once locked, COM bytes are idle (valid low) and all other bytes are data (valid high).

Parameters:
- COM, 8'hBC: comma/idle character used for alignment.
- COM_COUNT, 4: consecutive aligned COMs required to lock; legal range 1..15.
- MAX_RUN, 32: consecutive non-COM bytes tolerated before loss of sync; used only with RX_LOSS_DET_EN; legal range 2..255.

Ports:
- clk_32f  input  1  bit clock; one serial bit per rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial line bit, MSB of each byte first.
- data_out  output  8  last aligned byte; held stable for 8 cycles.
- valid_out  output  1  high while data_out holds a non-COM byte in LOCKED.
- active  output  1  high while in LOCKED.

Behaviour:
- Reset: asynchronous and active-high. Clears everything immediately, including mid-byte or while LOCKED.
  - data_out=8'h00, valid_out=0, active=0.
  - state=SEARCH; shreg, bit_cnt, com_cnt and run_cnt all 0.
- Shift register: shreg_n = {shreg[6:0], data_in} is loaded every cycle in all states.
- bit_cnt: 3-bit, increments every cycle and wraps 7->0. A byte boundary is any cycle with bit_cnt==7; the completed byte is shreg_n.
- SEARCH (bit-by-bit hunt): boundaries are ignored.
  - If shreg_n==COM: bit_cnt<=0 and com_cnt<=1.
  - Go to LOCKED if COM_COUNT==1, else to COUNT.
- COUNT (checked only at boundaries):
  - Byte==COM: com_cnt++. When it reaches COM_COUNT, go to LOCKED.
  - Byte!=COM: com_cnt<=0, return to SEARCH. Hunting resumes on the next cycle.
- LOCKED (checked only at boundaries):
  - data_out<=byte; valid_out<=(byte!=COM).
  - Misaligned COM patterns inside data are ignored.
- active is a registered output.
  - It rises on the same edge that enters LOCKED.
  - valid_out first rises at the first non-COM boundary after lock.
  - In SEARCH and COUNT, data_out holds its last value and valid_out=0.
- Latency: the last bit sampled at edge k appears on data_out/valid_out after edge k. Outputs change only at boundaries and are therefore constant for 8 cycles, which is sufficient for the downstream slower-clock sampler.
- Idle line: a constant 0 or 1 never matches 8'hBC, so the block stays in SEARCH.

Optional Feature:
- Macro: RX_LOSS_DET_EN.
- With the macro: run_cnt counts consecutive non-COM boundaries in LOCKED and is cleared by any COM boundary. When a non-COM boundary brings run_cnt to MAX_RUN, on that boundary:
  - state<=SEARCH, active<=0, valid_out<=0;
  - data_out keeps the new byte;
  - com_cnt and run_cnt <=0.
- Without the macro: LOCKED is left only by reset; run_cnt logic is absent.

Decomposition:
- Shared package rx_phy_pkg holds:
  - COM_CHAR=8'hBC;
  - state encoding SEARCH=2'd0, COUNT=2'd1, LOCKED=2'd2;
  - byte width constant 8.
- One natural sub-module: shift_in_reg8. It is the 8-bit serial shift register with async active-high reset and exposes shreg_n. Alignment FSM and counters stay in the top module.

Test Plan:
- Reset mid-stream: assert reset while LOCKED and mid-byte -> same cycle data_out=00, valid_out=0, active=0; relock requires COM_COUNT COMs again.
- Lock with 3 junk bits then BC x4 then A5, 3C, BC, 5A -> active rises at the 4th BC boundary; then data_out/valid_out = A5/1, 3C/1, BC/0, 5A/1, each held 8 cycles.
- Broken lock: BC, BC, 77 (COM_COUNT=4) -> returns to SEARCH, active stays 0; a subsequent BC x4 locks.
- Misaligned comma after lock: byte stream 0B, C0 (contains BC across the boundary) -> both delivered with valid_out=1, no realignment, active stays 1.
- COM_COUNT=1: single BC then 11 -> active after the BC; data_out=11, valid_out=1 one byte later.
- RX_LOSS_DET_EN, MAX_RUN=4: after lock send 4 non-COM bytes -> active and valid_out drop at the 4th boundary. Sending 3 non-COM, BC, 3 non-COM keeps lock.

Source files
------------

// File: rtl/rx_phy_pkg.sv
// rx_phy_pkg: shared constants and alignment state encoding for the rx serial-to-parallel path.
package rx_phy_pkg;
    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_CHAR = 8'hBC;
    typedef enum logic [1:0] {SEARCH = 2'd0, COUNT = 2'd1, LOCKED = 2'd2} state_t;
endpackage

// File: rtl/shift_in_reg8.sv
// shift_in_reg8: 8-bit MSB-first serial shift register exposing the next-cycle contents.
module shift_in_reg8
    import rx_phy_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              d,
    output logic [BYTE_W-1:0] shreg_n
);
    logic [BYTE_W-1:0] shreg;
    assign shreg_n = {shreg[BYTE_W-2:0], d};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shreg <= '0;
        else     shreg <= shreg_n;
    end
endmodule

// File: rtl/serial_paralelo_comalign_rx.sv
// serial_paralelo_comalign_rx: serial-to-parallel rx with COM byte alignment and lock.
// Define RX_LOSS_DET_EN to drop lock after MAX_RUN consecutive non-COM bytes.
module serial_paralelo_comalign_rx
    import rx_phy_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM = COM_CHAR,
    parameter int COM_COUNT = 4
`ifdef RX_LOSS_DET_EN
    ,
    parameter int MAX_RUN = 32
`endif
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active
);
    localparam logic [3:0] CC = 4'(COM_COUNT);
    state_t state, state_n;
    logic [BYTE_W-1:0] shreg_n, data_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] com_cnt, com_cnt_n;
    logic valid_n, active_n, bnd, is_com;
`ifdef RX_LOSS_DET_EN
    localparam logic [7:0] MR = 8'(MAX_RUN);
    logic [7:0] run_cnt, run_n;
`endif
    shift_in_reg8 u_shift (
        .clk     (clk_32f),
        .rst     (reset),
        .d       (data_in),
        .shreg_n (shreg_n)
    );
    assign bnd    = bit_cnt == 3'd7;
    assign is_com = shreg_n == COM;
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt + 3'd1;
        com_cnt_n = com_cnt;
        data_n    = data_out;
        valid_n   = valid_out;
`ifdef RX_LOSS_DET_EN
        run_n     = run_cnt;
`endif
        case (state)
            SEARCH: if (is_com) begin
                // restart the byte clock so the matched COM ends exactly on a boundary
                bit_cnt_n = 3'd0;
                com_cnt_n = 4'd1;
                state_n   = (COM_COUNT == 1) ? LOCKED : COUNT;
            end
            COUNT: if (bnd) begin
                com_cnt_n = is_com ? com_cnt + 4'd1 : 4'd0;
                state_n   = !is_com ? SEARCH : (com_cnt_n == CC) ? LOCKED : COUNT;
            end
            LOCKED: if (bnd) begin
                data_n  = shreg_n;
                valid_n = !is_com;
`ifdef RX_LOSS_DET_EN
                run_n = is_com ? 8'd0 : run_cnt + 8'd1;
                if (!is_com && run_n == MR) begin
                    state_n   = SEARCH;
                    valid_n   = 1'b0;
                    com_cnt_n = 4'd0;
                    run_n     = 8'd0;
                end
`endif
            end
            default: state_n = SEARCH;
        endcase
        active_n = state_n == LOCKED;
    end
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            bit_cnt   <= 3'd0;
            com_cnt   <= 4'd0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
`ifdef RX_LOSS_DET_EN
            run_cnt   <= 8'd0;
`endif
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            com_cnt   <= com_cnt_n;
            data_out  <= data_n;
            valid_out <= valid_n;
            active    <= active_n;
`ifdef RX_LOSS_DET_EN
            run_cnt   <= run_n;
`endif
        end
    end
endmodule

// File: tb/tb_serial_paralelo_comalign_rx.sv
// tb_serial_paralelo_comalign_rx: scoreboard bench comparing two DUTs (COM_COUNT 4 and 1) to a window-scan model.
module tb_serial_paralelo_comalign_rx;
    localparam logic [7:0] COM = 8'hBC;
    localparam int MAXB = 2048;
`ifdef RX_LOSS_DET_EN
    localparam int MR = 4;
`endif
    typedef struct packed {logic [7:0] d; logic v; logic a;} exp_t;
    typedef struct packed {exp_t e0; exp_t e1;} pair_t;

    logic clk_32f = 1'b0, reset = 1'b1, data_in = 1'b0;
    logic [7:0] d0, d1;
    logic v0, v1, a0, a1;
    always #5 clk_32f = ~clk_32f;

    serial_paralelo_comalign_rx #(.COM(COM), .COM_COUNT(4)
`ifdef RX_LOSS_DET_EN
        , .MAX_RUN(MR)
`endif
    ) dut0 (.clk_32f(clk_32f), .reset(reset), .data_in(data_in), .data_out(d0), .valid_out(v0), .active(a0));
    serial_paralelo_comalign_rx #(.COM(COM), .COM_COUNT(1)
`ifdef RX_LOSS_DET_EN
        , .MAX_RUN(MR)
`endif
    ) dut1 (.clk_32f(clk_32f), .reset(reset), .data_in(data_in), .data_out(d1), .valid_out(v1), .active(a1));

    bit    sb[MAXB];
    int    nbits = 0;
    exp_t  ex[2][MAXB];
    exp_t  cur;
    int    fillpos;
    pair_t q[$];
    int    checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s at %0t: got=%h want=%h", nm, $time, act, want);
        end
    endtask

    function automatic logic [7:0] byte_at(input int j);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) r = {r[6:0], (j - 7 + i >= 0) ? sb[j - 7 + i] : 1'b0};
        return r;
    endfunction

    // outputs take value nx from cycle c onward
    task automatic emit(input int u, input int c, input exp_t nx);
        while (fillpos < c) begin
            ex[u][fillpos] = cur;
            fillpos++;
        end
        cur = nx;
    endtask

    task automatic run_model(input int u, input int cc);
        int j, t, pos, lock;
        bit ok;
        logic [7:0] b;
`ifdef RX_LOSS_DET_EN
        int run;
`endif
        cur = '0;
        fillpos = 0;
        pos = 0;
        while (pos < nbits) begin
            j = pos;
            while (j < nbits && byte_at(j) != COM) j++;
            if (j >= nbits) break;
            ok = 1'b1;
            for (int m = 1; m < cc; m++) begin
                t = j + 8 * m;
                if (t >= nbits) begin ok = 1'b0; pos = nbits; break; end
                if (byte_at(t) != COM) begin ok = 1'b0; pos = t + 1; break; end
            end
            if (!ok) continue;
            lock = j + 8 * (cc - 1);
            emit(u, lock, {cur.d, 1'b0, 1'b1});
            pos = nbits;
`ifdef RX_LOSS_DET_EN
            run = 0;
`endif
            for (t = lock + 8; t < nbits; t += 8) begin
                b = byte_at(t);
`ifdef RX_LOSS_DET_EN
                run = (b == COM) ? 0 : run + 1;
                if (run == MR) begin
                    emit(u, t, {b, 1'b0, 1'b0});
                    pos = t + 1;
                    break;
                end
`endif
                emit(u, t, {b, b != COM, 1'b1});
            end
        end
        emit(u, nbits, cur);
    endtask

    task automatic add_fixed(input int n, input logic [7:0] v);
        for (int i = n - 1; i >= 0; i--) begin sb[nbits] = v[i]; nbits++; end
    endtask

    task automatic add_byte(input logic [7:0] b, input int times = 1);
        repeat (times) add_fixed(8, b);
    endtask

    task automatic add_rand_bits(input int n);
        repeat (n) begin sb[nbits] = 1'($urandom_range(0, 1)); nbits++; end
    endtask

    // plays the stored stream from reset release, then asserts reset asynchronously mid-cycle
    task automatic run_seg();
        run_model(0, 4);
        run_model(1, 1);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk_32f);
            reset = 1'b0;
            data_in = sb[k];
            q.push_back({ex[0][k], ex[1][k]});
        end
        @(negedge clk_32f);
        #2 reset = 1'b1;
        #1;
        chk("rst_data0", d0, 8'h00);
        chk("rst_valid0", {7'd0, v0}, 8'h00);
        chk("rst_active0", {7'd0, a0}, 8'h00);
        chk("rst_data1", d1, 8'h00);
        chk("rst_valid1", {7'd0, v1}, 8'h00);
        chk("rst_active1", {7'd0, a1}, 8'h00);
        data_in = 1'b0;
        nbits = 0;
    endtask

    initial begin
        pair_t p;
        forever begin
            @(posedge clk_32f);
            #1;
            if (q.size() > 0) begin
                p = q.pop_front();
                chk("data0", d0, p.e0.d);
                chk("valid0", {7'd0, v0}, {7'd0, p.e0.v});
                chk("active0", {7'd0, a0}, {7'd0, p.e0.a});
                chk("data1", d1, p.e1.d);
                chk("valid1", {7'd0, v1}, {7'd0, p.e1.v});
                chk("active1", {7'd0, a1}, {7'd0, p.e1.a});
            end
        end
    end

    initial begin
        int r;
        add_fixed(3, 8'b101);
        add_byte(COM, 4);
        add_byte(8'hA5); add_byte(8'h3C); add_byte(COM); add_byte(8'h5A);
        add_fixed(3, 8'b011);
        run_seg();
        add_byte(COM, 2); add_byte(8'h77); add_byte(COM, 4); add_byte(8'h11); add_byte(8'h22);
        run_seg();
        add_byte(COM, 4); add_byte(8'h0B); add_byte(8'hC0); add_byte(8'h33);
        run_seg();
        add_fixed(8, 8'hFF); add_byte(8'hFF, 4); add_byte(8'h00, 5);
        run_seg();
        add_byte(COM, 4);
        add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(COM);
        add_byte(8'h44); add_byte(8'h55); add_byte(8'h66); add_byte(COM);
        add_byte(8'h77); add_byte(8'h88); add_byte(8'h99); add_byte(8'hAA); add_byte(8'hCD);
        add_byte(COM, 4); add_byte(8'h12);
        run_seg();
        for (int s = 0; s < 10; s++) begin
            add_rand_bits($urandom_range(0, 15));
            for (int t = 0; t < 40; t++) begin
                r = $urandom_range(0, 99);
                if (r < 40) add_byte(COM);
                else if (r < 85) add_byte(8'($urandom_range(0, 255)));
                else add_rand_bits($urandom_range(1, 7));
            end
            run_seg();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
